// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store request pulses onto one valid/ready memory port.
// One transaction is outstanding at a time, and each side has a one-entry pending buffer.
module mem_port_arbiter #(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_ready,
  output logic [31:0] dmem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t      state_q, state_d;
  logic        pend_i_q, pend_i_d;
  logic [31:0] pend_i_addr_q, pend_i_addr_d;
  logic        pend_d_q, pend_d_d;
  logic [31:0] pend_d_addr_q, pend_d_addr_d;
  logic [31:0] pend_d_wdata_q, pend_d_wdata_d;
  logic [3:0]  pend_d_wstrb_q, pend_d_wstrb_d;
  logic        mem_valid_q, mem_valid_d;
  logic        mem_instr_q, mem_instr_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;

  logic launch, elig_i, elig_d, win_i, win_d;

  always_comb begin
    state_d        = state_q;
    pend_i_d       = pend_i_q;
    pend_i_addr_d  = pend_i_addr_q;
    pend_d_d       = pend_d_q;
    pend_d_addr_d  = pend_d_addr_q;
    pend_d_wdata_d = pend_d_wdata_q;
    pend_d_wstrb_d = pend_d_wstrb_q;
    mem_valid_d    = mem_valid_q;
    mem_instr_d    = mem_instr_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_wstrb_d    = mem_wstrb_q;

    launch = (state_q == IDLE) || mem_ready;
    elig_i = pend_i_q || imem_valid;
    elig_d = pend_d_q || dmem_valid;
    win_d  = elig_d && (DATA_PRIORITY || !elig_i);
    win_i  = elig_i && !win_d;

    if (launch) begin
      if (win_d) begin
        state_d     = BUSY_D;
        mem_valid_d = 1'b1;
        mem_instr_d = 1'b0;
        mem_addr_d  = pend_d_q ? pend_d_addr_q  : dmem_addr;
        mem_wdata_d = pend_d_q ? pend_d_wdata_q : dmem_wdata;
        mem_wstrb_d = pend_d_q ? pend_d_wstrb_q : dmem_wstrb;
        pend_d_d    = 1'b0;
        if (imem_valid) begin
          pend_i_d      = 1'b1;
          pend_i_addr_d = imem_addr;
        end
      end else if (win_i) begin
        state_d     = BUSY_I;
        mem_valid_d = 1'b1;
        mem_instr_d = 1'b1;
        mem_addr_d  = pend_i_q ? pend_i_addr_q : imem_addr;
        mem_wdata_d = '0;
        mem_wstrb_d = '0;
        pend_i_d    = 1'b0;
        if (dmem_valid) begin
          pend_d_d       = 1'b1;
          pend_d_addr_d  = dmem_addr;
          pend_d_wdata_d = dmem_wdata;
          pend_d_wstrb_d = dmem_wstrb;
        end
      end else begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
      end
    end else begin
      // Bus is stalled: park any new request until the next launch point.
      if (imem_valid) begin
        pend_i_d      = 1'b1;
        pend_i_addr_d = imem_addr;
      end
      if (dmem_valid) begin
        pend_d_d       = 1'b1;
        pend_d_addr_d  = dmem_addr;
        pend_d_wdata_d = dmem_wdata;
        pend_d_wstrb_d = dmem_wstrb;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      pend_i_q       <= 1'b0;
      pend_i_addr_q  <= '0;
      pend_d_q       <= 1'b0;
      pend_d_addr_q  <= '0;
      pend_d_wdata_q <= '0;
      pend_d_wstrb_q <= '0;
      mem_valid_q    <= 1'b0;
      mem_instr_q    <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_wstrb_q    <= '0;
    end else begin
      state_q        <= state_d;
      pend_i_q       <= pend_i_d;
      pend_i_addr_q  <= pend_i_addr_d;
      pend_d_q       <= pend_d_d;
      pend_d_addr_q  <= pend_d_addr_d;
      pend_d_wdata_q <= pend_d_wdata_d;
      pend_d_wstrb_q <= pend_d_wstrb_d;
      mem_valid_q    <= mem_valid_d;
      mem_instr_q    <= mem_instr_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_wstrb_q    <= mem_wstrb_d;
    end
  end

  assign mem_valid  = mem_valid_q;
  assign mem_instr  = mem_instr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;

  assign imem_ready = (state_q == BUSY_I) && mem_ready;
  assign dmem_ready = (state_q == BUSY_D) && mem_ready;
  assign imem_rdata = imem_ready ? mem_rdata : '0;
  assign dmem_rdata = dmem_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios on both priority settings plus a
// randomized run checked against a per-side request queue model.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_valid, dmem_valid, mem_ready;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
  logic [3:0]  dmem_wstrb;

  logic        imem_ready, dmem_ready, mem_valid, mem_instr;
  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        imem_ready_0, dmem_ready_0, mem_valid_0, mem_instr_0;
  logic [31:0] imem_rdata_0, dmem_rdata_0, mem_addr_0, mem_wdata_0;
  logic [3:0]  mem_wstrb_0;

  int unsigned checks = 0;
  int unsigned passes = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          launched;
  } req_t;

  req_t qi[$];
  req_t qd[$];

  always #5 clock = ~clock;

  mem_port_arbiter #(.DATA_PRIORITY(1'b1)) dut (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.DATA_PRIORITY(1'b0)) dut0 (
    .clock(clock), .reset(reset),
    .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_ready(imem_ready_0), .imem_rdata(imem_rdata_0),
    .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready_0), .dmem_rdata(dmem_rdata_0),
    .mem_valid(mem_valid_0), .mem_instr(mem_instr_0), .mem_addr(mem_addr_0), .mem_wdata(mem_wdata_0),
    .mem_wstrb(mem_wstrb_0), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Requester protocol: no new valid while that side's previous request is unanswered.
  logic i_out, d_out;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      i_out <= 1'b0;
      d_out <= 1'b0;
    end else begin
      assert (!(imem_valid && i_out && !imem_ready)) else $error("imem_valid issued while a fetch is in flight");
      assert (!(dmem_valid && d_out && !dmem_ready)) else $error("dmem_valid issued while a data access is in flight");
      i_out <= imem_valid || (i_out && !imem_ready);
      d_out <= dmem_valid || (d_out && !dmem_ready);
    end
  end

  task automatic clr_in;
    imem_valid = 1'b0; imem_addr = '0;
    dmem_valid = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    mem_ready  = 1'b0; mem_rdata = '0;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    clr_in();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    clr_in();
    #1;
    reset = 1'b1;
    #2;
    checks++;
    if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, imem_ready, dmem_ready, imem_rdata, dmem_rdata} !== '0) begin
      $display("FAIL reset_outputs: got %h want 0",
               {mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, imem_ready, dmem_ready, imem_rdata, dmem_rdata});
    end else passes++;
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({mem_valid_0, mem_instr_0, mem_addr_0, mem_wdata_0, mem_wstrb_0, imem_ready_0, dmem_ready_0, imem_rdata_0, dmem_rdata_0} !== '0) begin
      $display("FAIL reset_outputs_dp0: got %h want 0",
               {mem_valid_0, mem_instr_0, mem_addr_0, mem_wdata_0, mem_wstrb_0, imem_ready_0, dmem_ready_0, imem_rdata_0, dmem_rdata_0});
    end else passes++;
    do_reset();
  endtask

  task automatic test_single_fetch;
    do_reset();
    imem_valid = 1'b1; imem_addr = 32'h0000_0100;
    tick();
    clr_in();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin mem_ready = 1'b1; mem_rdata = 32'h0000_0013; end
      #1;
      checks++;
      if ({mem_valid, mem_instr, mem_wstrb, mem_addr} !== {1'b1, 1'b1, 4'h0, 32'h0000_0100}) begin
        $display("FAIL single_bus c%0d: got %h want %h", c, {mem_valid, mem_instr, mem_wstrb, mem_addr},
                 {1'b1, 1'b1, 4'h0, 32'h0000_0100});
      end else passes++;
      checks++;
      if ({imem_ready, imem_rdata, dmem_ready} !== ((c == 3) ? {1'b1, 32'h13, 1'b0} : 34'h0)) begin
        $display("FAIL single_ready c%0d: got %h", c, {imem_ready, imem_rdata, dmem_ready});
      end else passes++;
      tick();
    end
    clr_in();
    #1;
    checks++;
    if (mem_valid !== 1'b0) $display("FAIL single_idle: mem_valid got %b want 0", mem_valid);
    else passes++;
  endtask

  task automatic test_simultaneous;
    do_reset();
    imem_valid = 1'b1; imem_addr = 32'h0000_0200;
    dmem_valid = 1'b1; dmem_addr = 32'h8000_0004; dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hC;
    tick();
    clr_in();
    mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    #1;
    checks++;
    if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 4'hC})
      $display("FAIL simul_first: got %h want %h", {mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb},
               {1'b1, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 4'hC});
    else passes++;
    checks++;
    if ({dmem_ready, dmem_rdata, imem_ready} !== {1'b1, 32'h1111_1111, 1'b0})
      $display("FAIL simul_dready: got %h", {dmem_ready, dmem_rdata, imem_ready});
    else passes++;
    tick();
    mem_rdata = 32'h2222_2222;
    #1;
    checks++;
    if ({mem_valid, mem_instr, mem_addr, mem_wstrb} !== {1'b1, 1'b1, 32'h0000_0200, 4'h0})
      $display("FAIL simul_second: got %h want %h", {mem_valid, mem_instr, mem_addr, mem_wstrb},
               {1'b1, 1'b1, 32'h0000_0200, 4'h0});
    else passes++;
    checks++;
    if ({imem_ready, imem_rdata, dmem_ready} !== {1'b1, 32'h2222_2222, 1'b0})
      $display("FAIL simul_iready: got %h", {imem_ready, imem_rdata, dmem_ready});
    else passes++;
    tick();
    clr_in();
    #1;
    checks++;
    if (mem_valid !== 1'b0) $display("FAIL simul_idle: mem_valid got %b want 0", mem_valid);
    else passes++;
  endtask

  task automatic test_buffering;
    do_reset();
    dmem_valid = 1'b1; dmem_addr = 32'h0000_1000;
    tick();
    clr_in();
    for (int c = 1; c <= 5; c++) begin
      imem_valid = (c == 2);
      imem_addr  = (c == 2) ? 32'h0000_2000 : 32'h0;
      mem_ready  = (c == 4) || (c == 5);
      mem_rdata  = 32'hA5A5_0000 | c;
      #1;
      checks++;
      if ({mem_valid, mem_instr, mem_addr} !== ((c <= 4) ? {1'b1, 1'b0, 32'h1000} : {1'b1, 1'b1, 32'h2000}))
        $display("FAIL buffer_bus c%0d: got %h", c, {mem_valid, mem_instr, mem_addr});
      else passes++;
      checks++;
      if ({imem_ready, dmem_ready, dmem_rdata} !== {(c == 5), (c == 4), ((c == 4) ? 32'hA5A5_0004 : 32'h0)})
        $display("FAIL buffer_ready c%0d: got %h", c, {imem_ready, dmem_ready, dmem_rdata});
      else passes++;
      tick();
    end
    clr_in();
    #1;
    checks++;
    if (mem_valid !== 1'b0) $display("FAIL buffer_idle: mem_valid got %b want 0", mem_valid);
    else passes++;
  endtask

  task automatic test_chaining;
    do_reset();
    dmem_valid = 1'b1; dmem_addr = 32'h0000_0040;
    tick();
    clr_in();
    #1;
    checks++;
    if ({mem_valid, mem_addr, mem_valid_0, mem_addr_0} !== {1'b1, 32'h40, 1'b1, 32'h40})
      $display("FAIL chain_first: got %h", {mem_valid, mem_addr, mem_valid_0, mem_addr_0});
    else passes++;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'h0000_1234;
    dmem_valid = 1'b1; dmem_addr = 32'h0000_0044;
    imem_valid = 1'b1; imem_addr = 32'h0000_0300;
    #1;
    checks++;
    if ({dmem_ready, dmem_ready_0, dmem_rdata} !== {1'b1, 1'b1, 32'h1234})
      $display("FAIL chain_complete: got %h", {dmem_ready, dmem_ready_0, dmem_rdata});
    else passes++;
    tick();
    clr_in();
    mem_ready = 1'b1; mem_rdata = 32'h0000_5678;
    #1;
    checks++;
    if ({mem_valid, mem_instr, mem_addr, dmem_ready} !== {1'b1, 1'b0, 32'h44, 1'b1})
      $display("FAIL chain_dp1_next: got %h", {mem_valid, mem_instr, mem_addr, dmem_ready});
    else passes++;
    checks++;
    if ({mem_valid_0, mem_instr_0, mem_addr_0, imem_ready_0, imem_rdata_0} !== {1'b1, 1'b1, 32'h300, 1'b1, 32'h5678})
      $display("FAIL chain_dp0_next: got %h", {mem_valid_0, mem_instr_0, mem_addr_0, imem_ready_0, imem_rdata_0});
    else passes++;
    tick();
    #1;
    checks++;
    if ({mem_valid, mem_instr, mem_addr, imem_ready} !== {1'b1, 1'b1, 32'h300, 1'b1})
      $display("FAIL chain_dp1_then: got %h", {mem_valid, mem_instr, mem_addr, imem_ready});
    else passes++;
    checks++;
    if ({mem_valid_0, mem_instr_0, mem_addr_0, dmem_ready_0} !== {1'b1, 1'b0, 32'h44, 1'b1})
      $display("FAIL chain_dp0_then: got %h", {mem_valid_0, mem_instr_0, mem_addr_0, dmem_ready_0});
    else passes++;
    tick();
    clr_in();
    #1;
    checks++;
    if ({mem_valid, mem_valid_0} !== 2'b00) $display("FAIL chain_idle: got %b want 00", {mem_valid, mem_valid_0});
    else passes++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    dmem_valid = 1'b1; dmem_addr = 32'h0000_3000; dmem_wdata = 32'hCAFE_F00D; dmem_wstrb = 4'hF;
    tick();
    clr_in();
    #1;
    checks++;
    if ({mem_valid, mem_instr, mem_addr, mem_wstrb} !== {1'b1, 1'b0, 32'h3000, 4'hF})
      $display("FAIL rmid_store: got %h", {mem_valid, mem_instr, mem_addr, mem_wstrb});
    else passes++;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_valid, mem_addr, mem_wstrb, dmem_ready} !== '0)
      $display("FAIL rmid_async: got %h want 0", {mem_valid, mem_addr, mem_wstrb, dmem_ready});
    else passes++;
    @(posedge clock);
    #1;
    reset = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h0000_0BAD;
    #1;
    checks++;
    if ({dmem_ready, dmem_rdata, imem_ready} !== '0)
      $display("FAIL rmid_late_ready: got %h want 0", {dmem_ready, dmem_rdata, imem_ready});
    else passes++;
    tick();
    clr_in();
    #1;
    checks++;
    if (mem_valid !== 1'b0) $display("FAIL rmid_no_phantom: mem_valid got %b want 0", mem_valid);
    else passes++;
    imem_valid = 1'b1; imem_addr = 32'h0000_0400;
    tick();
    clr_in();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
    #1;
    checks++;
    if ({mem_valid, mem_instr, mem_addr, mem_wstrb, imem_ready, imem_rdata} !== {1'b1, 1'b1, 32'h400, 4'h0, 1'b1, 32'h77})
      $display("FAIL rmid_fetch: got %h", {mem_valid, mem_instr, mem_addr, mem_wstrb, imem_ready, imem_rdata});
    else passes++;
    tick();
    clr_in();
    #1;
    checks++;
    if (mem_valid !== 1'b0) $display("FAIL rmid_idle: mem_valid got %b want 0", mem_valid);
    else passes++;
  endtask

  task automatic test_random;
    int unsigned lat = 0;
    int unsigned n_i = 0, n_d = 0, done_i = 0, done_d = 0;
    bit active = 0, cur_instr = 0, prev_hold = 0, prev_valid = 0, prev_ready = 0, stop = 0;
    bit new_launch, exp_i, exp_d, ok;
    logic [68:0] snap = '0;
    req_t r;
    do_reset();
    qi.delete();
    qd.delete();
    for (int cyc = 0; cyc < 4300; cyc++) begin
      stop = (cyc >= 4000);
      if (stop && qi.size() == 0 && qd.size() == 0 && !mem_valid) break;
      if (prev_hold) begin
        checks++;
        if ({mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, snap})
          $display("FAIL rand_hold c%0d: got %h want %h", cyc, {mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb}, {1'b1, snap});
        else passes++;
      end
      new_launch = mem_valid && (!prev_valid || prev_ready);
      if (new_launch) begin
        if (mem_instr)
          ok = qi.size() > 0 && !qi[0].launched && mem_addr == qi[0].addr && mem_wstrb == 4'h0;
        else
          ok = qd.size() > 0 && !qd[0].launched && mem_addr == qd[0].addr &&
               mem_wdata == qd[0].wdata && mem_wstrb == qd[0].wstrb;
        checks++;
        if (!ok) $display("FAIL rand_launch c%0d: got instr=%b addr=%h wstrb=%h, no matching request", cyc, mem_instr, mem_addr, mem_wstrb);
        else begin
          passes++;
          if (mem_instr) qi[0].launched = 1'b1;
          else qd[0].launched = 1'b1;
        end
        active = 1'b1;
        cur_instr = mem_instr;
        lat = $urandom_range(1, 8);
      end
      if (!mem_valid) begin
        ok = !((qi.size() > 0 && !qi[0].launched) || (qd.size() > 0 && !qd[0].launched));
        checks++;
        if (!ok) $display("FAIL rand_bubble c%0d: mem_valid got 0 want 1 (request waiting)", cyc);
        else passes++;
      end
      mem_rdata = $urandom;
      if (active) begin
        mem_ready = (lat == 1);
        lat--;
      end else begin
        mem_ready = ($urandom_range(0, 7) == 0);
      end
      exp_i = active && mem_ready && cur_instr;
      exp_d = active && mem_ready && !cur_instr;
      if (exp_i && qi.size() > 0) begin void'(qi.pop_front()); done_i++; end
      if (exp_d && qd.size() > 0) begin void'(qd.pop_front()); done_d++; end
      imem_addr  = $urandom & 32'hFFFF_FFFC;
      dmem_addr  = $urandom & 32'hFFFF_FFFC;
      dmem_wdata = $urandom;
      dmem_wstrb = 4'($urandom_range(0, 15));
      imem_valid = !stop && qi.size() == 0 && ($urandom_range(0, 2) == 0);
      dmem_valid = !stop && qd.size() == 0 && ($urandom_range(0, 2) == 0);
      if (imem_valid) begin
        r.addr = imem_addr; r.wdata = '0; r.wstrb = '0; r.launched = 1'b0;
        qi.push_back(r);
        n_i++;
      end
      if (dmem_valid) begin
        r.addr = dmem_addr; r.wdata = dmem_wdata; r.wstrb = dmem_wstrb; r.launched = 1'b0;
        qd.push_back(r);
        n_d++;
      end
      #1;
      checks++;
      if ({imem_ready, dmem_ready} !== {exp_i, exp_d})
        $display("FAIL rand_ready c%0d: got %b want %b", cyc, {imem_ready, dmem_ready}, {exp_i, exp_d});
      else passes++;
      checks++;
      if ({imem_rdata, dmem_rdata} !== {(exp_i ? mem_rdata : 32'h0), (exp_d ? mem_rdata : 32'h0)})
        $display("FAIL rand_rdata c%0d: got %h want %h", cyc, {imem_rdata, dmem_rdata},
                 {(exp_i ? mem_rdata : 32'h0), (exp_d ? mem_rdata : 32'h0)});
      else passes++;
      prev_valid = mem_valid;
      prev_ready = mem_ready;
      prev_hold  = mem_valid && !mem_ready;
      snap       = {mem_instr, mem_addr, mem_wdata, mem_wstrb};
      if (active && mem_ready) active = 1'b0;
      tick();
    end
    clr_in();
    checks++;
    if (qi.size() != 0 || qd.size() != 0 || done_i != n_i || done_d != n_d || n_i < 50 || n_d < 50)
      $display("FAIL rand_drain: completed i=%0d/%0d d=%0d/%0d, required all", done_i, n_i, done_d, n_d);
    else passes++;
  endtask

  initial begin
    clr_in();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_buffering();
    test_chaining();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
